// File: rtl/cfg_cmd_arbiter_if.sv
// Executor-side command handshake used by cfg_cmd_arbiter.
// The arbiter drives the command as master; the executor answers as slave.
interface cfg_cmd_arbiter_if;
  logic        valid;
  logic        ready;
  logic [7:0]  command;
  logic [31:0] arg0;
  logic [31:0] arg1;
  logic        done;
  logic [31:0] response;

  modport master (output valid, command, arg0, arg1, input ready, done, response);
  modport slave  (input valid, command, arg0, arg1, output ready, done, response);
endinterface

// File: rtl/cfg_cmd_arbiter.sv
// Round-robin arbiter sharing one command executor between the N64 config port and the USB debug port.
// Optional completion timeout is compiled in with CFG_CMD_TIMEOUT_EN.
module cfg_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        n64_request,
  input  logic [7:0]  n64_command,
  input  logic [31:0] n64_arg0,
  input  logic [31:0] n64_arg1,
  output logic        n64_busy,
  output logic        n64_done,
  output logic        n64_error,
  output logic        n64_overrun,
  output logic [31:0] n64_response,
  input  logic        usb_request,
  input  logic [7:0]  usb_command,
  input  logic [31:0] usb_arg0,
  input  logic [31:0] usb_arg1,
  output logic        usb_busy,
  output logic        usb_done,
  output logic        usb_error,
  output logic        usb_overrun,
  output logic [31:0] usb_response,
  cfg_cmd_arbiter_if.master exec
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t      state;
  state_t      state_next;

  // Source index 0 is N64, index 1 is USB.
  logic [1:0]  request;
  logic [7:0]  req_command [2];
  logic [31:0] req_arg0    [2];
  logic [31:0] req_arg1    [2];

  logic [1:0]  pending;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  error;
  logic [1:0]  overrun;
  logic [7:0]  slot_command [2];
  logic [31:0] slot_arg0    [2];
  logic [31:0] slot_arg1    [2];
  logic [31:0] response     [2];

  logic        owner;
  logic        last_grant;
  logic        grant_src;
  logic        exec_valid;
  logic [7:0]  exec_command;
  logic [31:0] exec_arg0;
  logic [31:0] exec_arg1;
  logic        timeout_hit;
  logic        finish_ok;
  logic        finish_to;

  assign request        = {usb_request, n64_request};
  assign req_command[0] = n64_command;
  assign req_command[1] = usb_command;
  assign req_arg0[0]    = n64_arg0;
  assign req_arg0[1]    = usb_arg0;
  assign req_arg1[0]    = n64_arg1;
  assign req_arg1[1]    = usb_arg1;

`ifdef CFG_CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] count;

  // Cycles since grant; only advances while a command is outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (state == S_IDLE && (|pending)) begin
      count <= '0;
    end else if (state == S_ISSUE || state == S_WAIT) begin
      count <= count + CNT_W'(1);
    end
  end

  assign timeout_hit = (state == S_ISSUE || state == S_WAIT) && (count == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // A real completion arriving in the expiry cycle takes precedence over the timeout.
  assign finish_ok = (state == S_WAIT) && exec.done;
  assign finish_to = timeout_hit && !finish_ok;

  // Round-robin source choice and next-state decode.
  always_comb begin
    state_next = state;
    if (&pending) begin
      grant_src = ~last_grant;
    end else begin
      grant_src = pending[1];
    end
    case (state)
      S_IDLE: begin
        if (|pending) state_next = S_ISSUE;
        else          state_next = S_IDLE;
      end
      S_ISSUE: begin
        if (finish_to)                      state_next = S_DONE;
        else if (exec_valid && exec.ready)  state_next = S_WAIT;
        else                                state_next = S_ISSUE;
      end
      S_WAIT: begin
        if (finish_ok || finish_to) state_next = S_DONE;
        else                        state_next = S_WAIT;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Source slots, per-source status and the executor-facing command registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= 2'b00;
      busy         <= 2'b00;
      done         <= 2'b00;
      error        <= 2'b00;
      overrun      <= 2'b00;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      exec_valid   <= 1'b0;
      exec_command <= 8'h00;
      exec_arg0    <= 32'h0000_0000;
      exec_arg1    <= 32'h0000_0000;
      for (int s = 0; s < 2; s++) begin
        slot_command[s] <= 8'h00;
        slot_arg0[s]    <= 32'h0000_0000;
        slot_arg1[s]    <= 32'h0000_0000;
        response[s]     <= 32'h0000_0000;
      end
    end else begin
      done <= 2'b00;
      for (int s = 0; s < 2; s++) begin
        if (request[s]) begin
          if (!busy[s]) begin
            slot_command[s] <= req_command[s];
            slot_arg0[s]    <= req_arg0[s];
            slot_arg1[s]    <= req_arg1[s];
            pending[s]      <= 1'b1;
            busy[s]         <= 1'b1;
            error[s]        <= 1'b0;
            overrun[s]      <= 1'b0;
          end else begin
            overrun[s]      <= 1'b1;
          end
        end
      end
      case (state)
        S_IDLE: begin
          if (|pending) begin
            owner        <= grant_src;
            exec_valid   <= 1'b1;
            exec_command <= slot_command[grant_src];
            exec_arg0    <= slot_arg0[grant_src];
            exec_arg1    <= slot_arg1[grant_src];
          end
        end
        S_ISSUE: begin
          if (finish_to) begin
            exec_valid      <= 1'b0;
            response[owner] <= 32'hFFFF_FFFF;
            error[owner]    <= 1'b1;
          end else if (exec_valid && exec.ready) begin
            exec_valid      <= 1'b0;
          end
        end
        S_WAIT: begin
          if (finish_ok) begin
            response[owner] <= exec.response;
            error[owner]    <= 1'b0;
          end else if (finish_to) begin
            response[owner] <= 32'hFFFF_FFFF;
            error[owner]    <= 1'b1;
          end
        end
        S_DONE: begin
          done[owner]    <= 1'b1;
          busy[owner]    <= 1'b0;
          pending[owner] <= 1'b0;
          last_grant     <= owner;
        end
        default: begin
          exec_valid <= 1'b0;
        end
      endcase
    end
  end

  assign exec.valid   = exec_valid;
  assign exec.command = exec_command;
  assign exec.arg0    = exec_arg0;
  assign exec.arg1    = exec_arg1;

  assign n64_busy     = busy[0];
  assign n64_done     = done[0];
  assign n64_error    = error[0];
  assign n64_overrun  = overrun[0];
  assign n64_response = response[0];
  assign usb_busy     = busy[1];
  assign usb_done     = done[1];
  assign usb_error    = error[1];
  assign usb_overrun  = overrun[1];
  assign usb_response = response[1];

endmodule
